// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising instruction and data requests onto one RAM.
// Latches each granted request and forces completion if the RAM never answers.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              terr_q, terr_d;

  logic              dreq;
  logic              done;
  logic [DATA_W-1:0] rdata;

  assign dreq  = dREN | dWEN;
  assign done  = ram_ready | (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rdata = ram_ready ? ram_load : ERR_WORD;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wr_d      = wr_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    terr_d    = terr_q;
    iwait     = iREN;
    dwait     = dreq;
    iload     = iload_q;
    dload     = dload_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = addr_q;
    ram_store = store_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // last_q=0 means instruction was granted last
        if (dreq && (!iREN || !last_q)) begin
          state_d = DACC;
          last_d  = 1'b1;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (iREN) begin
          state_d = IACC;
          last_d  = 1'b0;
          addr_d  = iaddr;
          store_d = dstore;
          wr_d    = 1'b0;
        end
      end
      IACC: begin
        ram_ren = 1'b1;
        dwait   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = IDLE;
          if (!ram_ready) terr_d = 1'b1;
          if (iREN) begin
            iwait   = 1'b0;
            iload   = rdata;
            iload_d = rdata;
          end
        end
      end
      DACC: begin
        ram_ren = ~wr_q;
        ram_wen = wr_q;
        iwait   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = IDLE;
          if (!ram_ready) terr_d = 1'b1;
          if (dreq) begin
            dwait = 1'b0;
            if (!wr_q) begin
              dload   = rdata;
              dload_d = rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign timeout_err = terr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable RAM model
// and an in-order completion scoreboard.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic        ram_ready;
  logic        timeout_err;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total = 0;
  int comps = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h8C220044;
  endfunction

  // RAM model: ready after lat cycles of a held strobe
  int          age = 0;
  int          lat = 1;
  bit          never = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  bit          st_valid = 1'b0;

  always @(posedge CLK) begin
    if ((ram_ren || ram_wen) && !ram_ready) age <= age + 1;
    else age <= 0;
    if (ram_wen && ram_ready) begin
      st_addr  <= ram_addr;
      st_data  <= ram_store;
      st_valid <= 1'b1;
    end
  end

  always_comb begin
    ram_ready = (ram_ren || ram_wen) && !never && (age == lat);
    ram_load  = (st_valid && ram_addr == st_addr) ? st_data : f(ram_addr);
  end

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  bit   prev_done = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (RST !== 1'b0) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done)
        chk("idle_gap", 64'({ram_ren, ram_wen}), 64'(0));
      prev_done = 1'b0;
      if (iREN && !iwait) begin
        chk("sb_has_entry_i", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("grant_cls_i", 64'(e.is_d), 64'(0));
          chk("iload", 64'(iload), 64'(e.val));
        end
        prev_done = 1'b1;
        comps++;
      end
      if ((dREN || dWEN) && !dwait) begin
        chk("sb_has_entry_d", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("grant_cls_d", 64'(e.is_d), 64'(1));
          if (!e.is_wr) chk("dload", 64'(dload), 64'(e.val));
        end
        prev_done = 1'b1;
        comps++;
      end
    end
  end

  task automatic nclk();
    @(negedge CLK);
    #1;
  endtask

  task automatic pclk();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_comps(input int n, input int budget, input string tag);
    int t = 0;
    while (comps < n && t < budget) begin
      nclk();
      t++;
    end
    chk(tag, 64'(comps >= n), 64'(1));
  endtask

  function automatic exp_t mk(input bit d, input bit w, input logic [31:0] v);
    exp_t e;
    e.is_d  = d;
    e.is_wr = w;
    e.val   = v;
    return e;
  endfunction

  initial begin
    int base;
    int n;
    RST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h20; daddr = 32'h100; dstore = '0;

    // reset with both requests up
    pclk();
    pclk();
    nclk();
    chk("rst_iwait", 64'(iwait), 64'(1));
    chk("rst_dwait", 64'(dwait), 64'(1));
    chk("rst_ren", 64'(ram_ren), 64'(0));
    chk("rst_wen", 64'(ram_wen), 64'(0));
    chk("rst_addr", 64'(ram_addr), 64'(0));
    chk("rst_store", 64'(ram_store), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    chk("rst_iload", 64'(iload), 64'(0));
    chk("rst_dload", 64'(dload), 64'(0));
    sb.push_back(mk(1, 0, f(32'h100)));
    pclk();
    RST = 1'b0;
    nclk();
    chk("rel_c0_ren", 64'(ram_ren), 64'(0));
    nclk();
    chk("rel_c1_ren", 64'(ram_ren), 64'(1));
    chk("rel_c1_addr", 64'(ram_addr), 64'(32'h100));
    wait_comps(1, 10, "rel_done");
    pclk();
    iREN = 1'b0; dREN = 1'b0;
    nclk();

    // single fetch, latency 2
    pclk();
    lat = 2;
    sb.push_back(mk(0, 0, 32'h8C220004));
    iREN = 1'b1; iaddr = 32'h40;
    nclk();
    chk("f_c0_ren", 64'(ram_ren), 64'(0));
    chk("f_c0_iwait", 64'(iwait), 64'(1));
    nclk();
    chk("f_c1_ren", 64'(ram_ren), 64'(1));
    chk("f_c1_addr", 64'(ram_addr), 64'(32'h40));
    nclk();
    chk("f_c2_iwait", 64'(iwait), 64'(1));
    nclk();
    chk("f_c3_iwait", 64'(iwait), 64'(0));
    chk("f_c3_iload", 64'(iload), 64'(32'h8C220004));
    pclk();
    iREN = 1'b0;
    nclk();
    chk("f_c4_ren", 64'(ram_ren), 64'(0));

    // store, latency 1; held one extra cycle to see dwait rise again
    pclk();
    lat = 1;
    base = comps;
    sb.push_back(mk(1, 1, '0));
    sb.push_back(mk(1, 1, '0));
    dWEN = 1'b1; daddr = 32'h3000; dstore = 32'hDEADBEEF;
    nclk();
    chk("s_c0_wen", 64'(ram_wen), 64'(0));
    nclk();
    chk("s_c1_wen", 64'(ram_wen), 64'(1));
    chk("s_c1_ren", 64'(ram_ren), 64'(0));
    chk("s_c1_addr", 64'(ram_addr), 64'(32'h3000));
    chk("s_c1_store", 64'(ram_store), 64'(32'hDEADBEEF));
    chk("s_c1_dwait", 64'(dwait), 64'(1));
    nclk();
    chk("s_c2_dwait", 64'(dwait), 64'(0));
    nclk();
    chk("s_c3_dwait", 64'(dwait), 64'(1));
    chk("s_c3_wen", 64'(ram_wen), 64'(0));
    wait_comps(base + 2, 20, "s_done");
    pclk();
    dWEN = 1'b0; dstore = '0;

    // contention: last grant was data, so instruction goes first
    base = comps;
    sb.push_back(mk(0, 0, f(32'h80)));
    sb.push_back(mk(1, 0, 32'hDEADBEEF));
    sb.push_back(mk(0, 0, f(32'h80)));
    sb.push_back(mk(1, 0, 32'hDEADBEEF));
    iREN = 1'b1; iaddr = 32'h80;
    dREN = 1'b1; daddr = 32'h3000;
    wait_comps(base + 4, 40, "c_done");
    pclk();
    iREN = 1'b0; dREN = 1'b0;
    nclk();
    chk("c_sb_drained", 64'(sb.size()), 64'(0));

    // timeout: RAM never answers
    pclk();
    never = 1'b1;
    base = comps;
    sb.push_back(mk(1, 0, 32'hBAD1BAD1));
    dREN = 1'b1; daddr = 32'h200;
    n = 0;
    do begin
      nclk();
      n++;
    end while (comps == base && n < 40);
    chk("t_cycles", 64'(n), 64'(17));
    pclk();
    dREN = 1'b0;
    never = 1'b0;
    nclk();
    chk("t_terr", 64'(timeout_err), 64'(1));
    chk("t_dload_hold", 64'(dload), 64'(32'hBAD1BAD1));
    pclk();
    base = comps;
    sb.push_back(mk(0, 0, 32'h8C220000));
    iREN = 1'b1; iaddr = 32'h44;
    wait_comps(base + 1, 20, "t_fetch_done");
    pclk();
    iREN = 1'b0;
    nclk();
    chk("t_terr_sticky", 64'(timeout_err), 64'(1));

    // withdraw one cycle into IACC
    pclk();
    lat = 3;
    base = comps;
    iREN = 1'b1; iaddr = 32'h48;
    nclk();
    nclk();
    chk("w_c1_ren", 64'(ram_ren), 64'(1));
    chk("w_c1_addr", 64'(ram_addr), 64'(32'h48));
    pclk();
    iREN = 1'b0;
    nclk();
    chk("w_c2_ren", 64'(ram_ren), 64'(1));
    chk("w_c2_iwait", 64'(iwait), 64'(0));
    nclk();
    chk("w_c3_ren", 64'(ram_ren), 64'(1));
    nclk();
    chk("w_c4_ren", 64'(ram_ren), 64'(1));
    chk("w_c4_iload", 64'(iload), 64'(32'h8C220000));
    nclk();
    chk("w_c5_ren", 64'(ram_ren), 64'(0));
    chk("w_c5_iload", 64'(iload), 64'(32'h8C220000));
    chk("w_no_comp", 64'(comps), 64'(base));

    // reset in the middle of a data access
    pclk();
    lat = 5;
    dREN = 1'b1; daddr = 32'h300;
    nclk();
    nclk();
    chk("r_c1_ren", 64'(ram_ren), 64'(1));
    pclk();
    RST = 1'b1; dREN = 1'b0;
    nclk();
    chk("r_c2_ren", 64'(ram_ren), 64'(1));
    pclk();
    RST = 1'b0;
    nclk();
    chk("r_c3_ren", 64'(ram_ren), 64'(0));
    chk("r_c3_addr", 64'(ram_addr), 64'(0));
    chk("r_c3_terr", 64'(timeout_err), 64'(0));
    chk("r_c3_iload", 64'(iload), 64'(0));
    chk("r_c3_dload", 64'(dload), 64'(0));
    nclk();
    chk("r_c4_ren", 64'(ram_ren), 64'(0));
    chk("end_sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
